// File: rtl/ddr_dqs_lane_delay_tuner_if.sv
// -----------------------------------------------------------------------------
// ddr_dqs_lane_delay_tuner_if
//
// Purpose:
//   Bundles the fabric handshake and the per-lane IOD delay-line / eye-monitor
//   signals of the read-DQS delay tuner. Signal prefixes are relative to the
//   tuner: i_* flow into the tuner, o_* flow out of it.
//
// Signals:
//   i_start                     fabric training start pulse
//   i_eye_monitor_early[L]      per-lane early flag from the IOD
//   i_eye_monitor_late[L]       per-lane late flag from the IOD
//   i_delay_line_out_of_range[L] per-lane delay-line range error from the IOD
//   o_delay_line_load[L]        per-lane delay-line load strobe
//   o_delay_line_move[L]        per-lane one-tap move strobe
//   o_delay_line_direction[L]   1 = increment, 0 = decrement
//   o_eye_monitor_clear_flags[L] per-lane eye-monitor flag clear strobe
//   o_tap_value[L*TAP_BITS]     current tap per lane, lane i at [i*TAP_BITS +: TAP_BITS]
//   o_lane_locked[L]            lane trained successfully
//   o_lane_err[L]               lane training failed
//   o_busy                      training in progress
//   o_done                      all lanes finished (level)
//
// Modports:
//   master : the tuner itself
//   slave  : fabric training logic plus the IOD lanes
// -----------------------------------------------------------------------------
interface ddr_dqs_lane_delay_tuner_if #(
  parameter int NUM_LANES = 2,
  parameter int TAP_BITS  = 8
);

  logic                          i_start;
  logic [NUM_LANES-1:0]          i_eye_monitor_early;
  logic [NUM_LANES-1:0]          i_eye_monitor_late;
  logic [NUM_LANES-1:0]          i_delay_line_out_of_range;
  logic [NUM_LANES-1:0]          o_delay_line_load;
  logic [NUM_LANES-1:0]          o_delay_line_move;
  logic [NUM_LANES-1:0]          o_delay_line_direction;
  logic [NUM_LANES-1:0]          o_eye_monitor_clear_flags;
  logic [NUM_LANES*TAP_BITS-1:0] o_tap_value;
  logic [NUM_LANES-1:0]          o_lane_locked;
  logic [NUM_LANES-1:0]          o_lane_err;
  logic                          o_busy;
  logic                          o_done;

  modport master (
    input  i_start,
    input  i_eye_monitor_early,
    input  i_eye_monitor_late,
    input  i_delay_line_out_of_range,
    output o_delay_line_load,
    output o_delay_line_move,
    output o_delay_line_direction,
    output o_eye_monitor_clear_flags,
    output o_tap_value,
    output o_lane_locked,
    output o_lane_err,
    output o_busy,
    output o_done
  );

  modport slave (
    output i_start,
    output i_eye_monitor_early,
    output i_eye_monitor_late,
    output i_delay_line_out_of_range,
    input  o_delay_line_load,
    input  o_delay_line_move,
    input  o_delay_line_direction,
    input  o_eye_monitor_clear_flags,
    input  o_tap_value,
    input  o_lane_locked,
    input  o_lane_err,
    input  o_busy,
    input  o_done
  );

endinterface : ddr_dqs_lane_delay_tuner_if

// File: rtl/ddr_dqs_lane_delay_tuner.sv
// -----------------------------------------------------------------------------
// ddr_dqs_lane_delay_tuner
//
// Purpose:
//   Read-DQS delay-line training controller for a DDR3 PHY. Lanes are trained
//   one after another: after a delay-line load, each lane repeatedly clears its
//   eye-monitor flags, waits for them to settle, samples early/late and either
//   counts a balanced sample towards lock or steps the delay line one tap
//   towards the eye centre. A lane ends locked, or in error on an IOD range
//   error, a move request past either end of the tap range, or too many steps.
//
// Ports:
//   i_fab_clk  fabric clock, rising edge
//   i_arst     asynchronous active-high reset
//   bus        ddr_dqs_lane_delay_tuner_if.master (fabric + IOD signals)
//
// Timing:
//   All strobes are registered and derived from the next state, so a strobe is
//   high for exactly the one cycle the FSM spends in the matching state, and
//   the tap change of a move is visible in the same cycle as its move strobe.
// -----------------------------------------------------------------------------
module ddr_dqs_lane_delay_tuner #(
  parameter int NUM_LANES     = 2,
  parameter int TAP_BITS      = 8,
  parameter int INIT_TAP      = 1,
  parameter int SETTLE_CYCLES = 8,
  parameter int LOCK_COUNT    = 4,
  parameter int MAX_STEPS     = 64
) (
  input  logic                         i_fab_clk,
  input  logic                         i_arst,
  ddr_dqs_lane_delay_tuner_if.master   bus
);

  localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int LOCK_W   = $clog2(LOCK_COUNT + 1);
  localparam int STEP_W   = $clog2(MAX_STEPS + 1);

  localparam logic [LANE_W-1:0]    LAST_LANE   = LANE_W'(NUM_LANES - 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [LOCK_W-1:0]    LOCK_LAST   = LOCK_W'(LOCK_COUNT - 1);
  localparam logic [STEP_W-1:0]    STEP_LIMIT  = STEP_W'(MAX_STEPS);
  localparam logic [TAP_BITS-1:0]  TAP_INIT    = TAP_BITS'(INIT_TAP);
  localparam logic [TAP_BITS-1:0]  TAP_TOP     = '1;
  localparam logic [NUM_LANES-1:0] LANE_ONE    = NUM_LANES'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_SETTLE,
    S_SAMPLE,
    S_DIR,
    S_MOVE,
    S_NEXT,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [LANE_W-1:0]     r_lane;
  logic [SETTLE_W-1:0]   r_settle;
  logic [LOCK_W-1:0]     r_lock;
  logic [STEP_W-1:0]     r_step;
  logic [TAP_BITS-1:0]   r_tap [NUM_LANES];
  logic [NUM_LANES-1:0]  r_load;
  logic [NUM_LANES-1:0]  r_move;
  logic [NUM_LANES-1:0]  r_clear;
  logic [NUM_LANES-1:0]  r_dir;
  logic [NUM_LANES-1:0]  r_locked;
  logic [NUM_LANES-1:0]  r_err;
  logic                  r_busy;
  logic                  r_done;

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  state_t                w_state_nxt;
  logic [LANE_W-1:0]     w_lane_nxt;
  logic [SETTLE_W-1:0]   w_settle_nxt;
  logic [LOCK_W-1:0]     w_lock_nxt;
  logic [STEP_W-1:0]     w_step_nxt;
  logic                  w_set_err;
  logic                  w_set_lock;

  // Only the lane currently being trained is looked at; the other lanes'
  // flags are don't-care.
  logic                  w_early;
  logic                  w_late;
  logic                  w_oor;
  logic [TAP_BITS-1:0]   w_tap_cur;
  logic                  w_balanced;
  logic                  w_at_limit;

  assign w_early    = bus.i_eye_monitor_early[r_lane];
  assign w_late     = bus.i_eye_monitor_late[r_lane];
  assign w_oor      = bus.i_delay_line_out_of_range[r_lane];
  assign w_tap_cur  = r_tap[r_lane];
  assign w_balanced = ~(w_early ^ w_late);
  // An early sample asks for an increment, a late one for a decrement; the
  // request is refused when it would run off the end of the tap range.
  assign w_at_limit = w_early ? (w_tap_cur == TAP_TOP) : (w_tap_cur == '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_lane_nxt   = r_lane;
    w_settle_nxt = r_settle;
    w_lock_nxt   = r_lock;
    w_step_nxt   = r_step;
    w_set_err    = 1'b0;
    w_set_lock   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_state_nxt = S_LOAD;
      end

      S_LOAD: begin
        w_lane_nxt  = '0;
        w_lock_nxt  = '0;
        w_step_nxt  = '0;
        w_state_nxt = S_CLEAR;
      end

      S_CLEAR: begin
        // Loaded with N-1 so SETTLE lasts exactly SETTLE_CYCLES cycles.
        w_settle_nxt = SETTLE_LOAD;
        w_state_nxt  = S_SETTLE;
      end

      S_SETTLE: begin
        if (r_settle == '0) w_state_nxt = S_SAMPLE;
        else                w_settle_nxt = r_settle - 1'b1;
      end

      S_SAMPLE: begin
        if (w_oor) begin
          w_set_err   = 1'b1;
          w_state_nxt = S_NEXT;
        end else if (w_balanced) begin
          if (r_lock == LOCK_LAST) begin
            w_set_lock  = 1'b1;
            w_state_nxt = S_NEXT;
          end else begin
            w_lock_nxt  = r_lock + 1'b1;
            w_state_nxt = S_CLEAR;
          end
        end else begin
          w_lock_nxt = '0;
          if (w_at_limit || (r_step == STEP_LIMIT)) begin
            w_set_err   = 1'b1;
            w_state_nxt = S_NEXT;
          end else begin
            w_state_nxt = S_DIR;
          end
        end
      end

      S_DIR: begin
        w_state_nxt = S_MOVE;
      end

      S_MOVE: begin
        w_step_nxt  = r_step + 1'b1;
        w_state_nxt = S_CLEAR;
      end

      S_NEXT: begin
        w_lock_nxt = '0;
        w_step_nxt = '0;
        if (r_lane == LAST_LANE) begin
          w_state_nxt = S_DONE;
        end else begin
          w_lane_nxt  = r_lane + 1'b1;
          w_state_nxt = S_CLEAR;
        end
      end

      S_DONE: begin
        if (bus.i_start) w_state_nxt = S_LOAD;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_fab_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state  <= S_IDLE;
      r_lane   <= '0;
      r_settle <= '0;
      r_lock   <= '0;
      r_step   <= '0;
      r_load   <= '0;
      r_move   <= '0;
      r_clear  <= '0;
      r_dir    <= '0;
      r_locked <= '0;
      r_err    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      // NOTE: the tap array is reset element by element; it is reported
      // status that must read INIT_TAP straight out of reset, unlike a
      // data RAM that could be left unreset.
      for (int i = 0; i < NUM_LANES; i++) begin
        r_tap[i] <= TAP_INIT;
      end
    end else begin
      r_state  <= w_state_nxt;
      r_lane   <= w_lane_nxt;
      r_settle <= w_settle_nxt;
      r_lock   <= w_lock_nxt;
      r_step   <= w_step_nxt;

      // Strobes follow the state being entered, giving one registered pulse
      // per visit of LOAD / CLEAR / MOVE.
      r_load  <= {NUM_LANES{w_state_nxt == S_LOAD}};
      r_clear <= (w_state_nxt == S_CLEAR) ? (LANE_ONE << w_lane_nxt) : '0;
      r_move  <= (w_state_nxt == S_MOVE)  ? (LANE_ONE << w_lane_nxt) : '0;
      r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done  <= (w_state_nxt == S_DONE);

      if (w_state_nxt == S_LOAD) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          r_tap[i] <= TAP_INIT;
        end
        r_locked <= '0;
        r_err    <= '0;
      end

      if (w_set_err)  r_err[r_lane]    <= 1'b1;
      if (w_set_lock) r_locked[r_lane] <= 1'b1;

      // Direction is set one cycle ahead of the move and simply held
      // afterwards, so the IOD sees it stable around the move strobe.
      if (w_state_nxt == S_DIR) r_dir[r_lane] <= w_early;

      // The tap counter tracks the IOD, changing in the same cycle the move
      // strobe is presented.
      if (w_state_nxt == S_MOVE) begin
        r_tap[r_lane] <= r_dir[r_lane] ? (w_tap_cur + 1'b1) : (w_tap_cur - 1'b1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_tap_out
    assign bus.o_tap_value[g*TAP_BITS +: TAP_BITS] = r_tap[g];
  end

  assign bus.o_delay_line_load         = r_load;
  assign bus.o_delay_line_move         = r_move;
  assign bus.o_delay_line_direction    = r_dir;
  assign bus.o_eye_monitor_clear_flags = r_clear;
  assign bus.o_lane_locked             = r_locked;
  assign bus.o_lane_err                = r_err;
  assign bus.o_busy                    = r_busy;
  assign bus.o_done                    = r_done;

endmodule : ddr_dqs_lane_delay_tuner
